// File: rtl/coin_accumulator.sv
// Coin front end for the vending FSM: validates denominations, accumulates credit, and locks out bounce.
// Optional lifetime accept counter is enabled with `define COIN_ACCUMULATOR_AUDIT_EN.
module coin_accumulator #(
  parameter logic [6:0] COIN0_VALUE   = 7'd1,
  parameter logic [6:0] COIN1_VALUE   = 7'd2,
  parameter logic [6:0] COIN2_VALUE   = 7'd5,
  parameter logic [6:0] COIN3_VALUE   = 7'd10,
  parameter logic [6:0] COIN4_VALUE   = 7'd20,
  parameter logic [6:0] MAX_CREDIT    = 7'd99,
  parameter int         SETTLE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_clear,
  input  logic       i_coin_valid,
  input  logic [2:0] i_coin_code,
  output logic [6:0] o_total_coin_value,
  output logic       o_coin_accept,
  output logic       o_coin_reject,
  output logic       o_busy,
  output logic [7:0] o_coin_count
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {DISABLED, READY, SETTLE} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] total_q, total_d;
  logic       accept_d, reject_d;
  logic [7:0] coin_val, sum;
  logic       coin_ok, fits;

  always_comb begin
    coin_ok  = 1'b1;
    coin_val = 8'd0;
    case (i_coin_code)
      3'd0:    coin_val = {1'b0, COIN0_VALUE};
      3'd1:    coin_val = {1'b0, COIN1_VALUE};
      3'd2:    coin_val = {1'b0, COIN2_VALUE};
      3'd3:    coin_val = {1'b0, COIN3_VALUE};
      3'd4:    coin_val = {1'b0, COIN4_VALUE};
      default: coin_ok  = 1'b0;
    endcase
  end

  // 8-bit sum so a coin that would push past the cap is caught instead of wrapping
  assign sum  = {1'b0, total_q} + coin_val;
  assign fits = coin_ok && (sum <= {1'b0, MAX_CREDIT});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    total_d  = total_q;
    accept_d = 1'b0;
    reject_d = 1'b0;
    if (i_clear) begin
      total_d  = 7'd0;
      cnt_d    = 4'd0;
      reject_d = i_coin_valid;
      state_d  = i_enable ? READY : DISABLED;
    end else begin
      case (state_q)
        DISABLED: begin
          reject_d = i_coin_valid;
          if (i_enable) state_d = READY;
        end
        READY: begin
          if (!i_enable) begin
            state_d  = DISABLED;
            reject_d = i_coin_valid;
          end else if (i_coin_valid) begin
            if (fits) begin
              accept_d = 1'b1;
              total_d  = sum[6:0];
              cnt_d    = SETTLE_LOAD;
              state_d  = SETTLE;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
        SETTLE: begin
          // bounce strobes are returned without restarting the window
          reject_d = i_coin_valid;
          if (!i_enable) begin
            state_d = DISABLED;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = READY;
          end
        end
        default: begin
          state_d = DISABLED;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= DISABLED;
      cnt_q         <= 4'd0;
      total_q       <= 7'd0;
      o_coin_accept <= 1'b0;
      o_coin_reject <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      total_q       <= total_d;
      o_coin_accept <= accept_d;
      o_coin_reject <= reject_d;
      o_busy        <= (state_d == SETTLE);
    end
  end

  assign o_total_coin_value = total_q;

`ifdef COIN_ACCUMULATOR_AUDIT_EN
  logic [7:0] count_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         count_q <= 8'd0;
    else if (accept_d) count_q <= count_q + 8'd1;
  end
  assign o_coin_count = count_q;
`else
  assign o_coin_count = 8'd0;
`endif

  a_one_outcome: assert property (@(posedge i_clk) disable iff (i_rst)
    !(o_coin_accept && o_coin_reject));
  a_cap: assert property (@(posedge i_clk) disable iff (i_rst)
    o_total_coin_value <= MAX_CREDIT);

endmodule

// File: doc/coin_accumulator.md
# coin_accumulator

Upstream stage of the vending machine FSM. It accepts one coin event at a time from the coin mechanism, validates the denomination, and accumulates a running 7-bit credit. That credit drives the vending machine's `i_total_coin_value`. The credit is cleared when the downstream FSM completes a vend or cancel. A post-coin settle window rejects mechanism bounce.

## Interface
Parameters:
- `COIN0_VALUE`, default 7'd1: credit for code 3'b000
- `COIN1_VALUE`, default 7'd2: credit for code 3'b001
- `COIN2_VALUE`, default 7'd5: credit for code 3'b010
- `COIN3_VALUE`, default 7'd10: credit for code 3'b011
- `COIN4_VALUE`, default 7'd20: credit for code 3'b100
- `MAX_CREDIT`, default 7'd99: highest credit the block will hold
- `SETTLE_CYCLES`, default 4: lockout cycles after an accepted coin (range 1..15)

Ports:
- `i_clk` in 1: clock
- `i_rst` in 1: reset, asynchronous, active-high
- `i_enable` in 1: high while downstream FSM is in a product-selection state
- `i_clear` in 1: single-cycle pulse from downstream on dispense or cancel
- `i_coin_valid` in 1: coin event strobe, one cycle per coin
- `i_coin_code` in 3: denomination code, sampled with `i_coin_valid`
- `o_total_coin_value` out 7: accumulated credit (registered)
- `o_coin_accept` out 1: one-cycle pulse, coin credited
- `o_coin_reject` out 1: one-cycle pulse, coin returned to user
- `o_busy` out 1: high during settle window
- `o_coin_count` out 8: lifetime accepted-coin count (see Configuration)

## Operation
- FSM states are DISABLED, READY and SETTLE. The reset state is DISABLED.
- DISABLED:
  - `i_enable`=1 → READY.
  - Any `i_coin_valid` → reject.
- READY:
  - `i_enable`=0 → DISABLED.
  - `i_coin_valid`=1 → decode.
    - Code 0..4 with total+value ≤ MAX_CREDIT: accept, total += value, → SETTLE.
    - Code 5..7: reject, stay READY.
    - Overflow (total+value > MAX_CREDIT): reject, total unchanged, stay READY.
- SETTLE:
  - The counter loads SETTLE_CYCLES on entry and decrements each cycle.
  - The counter reaches 0 → READY.
  - Any `i_coin_valid` → reject; the counter is not restarted.
  - `i_enable`=0 → DISABLED immediately, counter cleared.
- `i_clear` has priority over everything except reset:
  - total ← 0, counter ← 0.
  - A coin in the same cycle is rejected.
  - Next state: READY if `i_enable`, else DISABLED.
- Credit is held in DISABLED. The downstream FSM reads the total during its dispense state while `i_enable` is low.
- Addition is done at 8 bits and compared against MAX_CREDIT, so the total never wraps.
- Exactly one of accept or reject fires per `i_coin_valid`. Neither fires without `i_coin_valid`.

## Timing
- All outputs are registered. Reset values:
  - `o_total_coin_value`=0
  - `o_coin_accept`=0
  - `o_coin_reject`=0
  - `o_busy`=0
  - `o_coin_count`=0
- `i_coin_valid` sampled at edge N → accept/reject pulse and updated total visible after edge N (one cycle latency).
- `o_busy` rises in the same cycle as `o_coin_accept` and stays high for SETTLE_CYCLES cycles. The next coin can be accepted at the edge after `o_busy` falls.
- `i_clear` at edge N → total is 0 after edge N.
- Async reset mid-settle returns to DISABLED immediately. Credit is lost, and that is the intended behaviour.

## Configuration
- Macro: `COIN_ACCUMULATOR_AUDIT_EN`.
- Defined:
  - `o_coin_count` increments on every accept and wraps 255→0.
  - It is cleared only by `i_rst`, never by `i_clear`.
- Undefined:
  - The counter logic is omitted and `o_coin_count` is tied to 8'd0.
  - All other behaviour is identical.

## Test plan
- Basic accumulation: enable, then coins code 2, 3, 4 spaced ≥6 cycles apart.
  - Total reads 5, 15, 35, with three accept pulses.
  - `o_coin_count`=3 with AUDIT_EN defined.
- Bounce: code 3 accepted, then a second code-3 strobe 2 cycles later.
  - Second coin is rejected (`o_busy`=1), total stays 10.
  - A code-3 strobe after `o_busy` falls is accepted, total=20.
- Invalid and overflow:
  - Code 6 → reject, total unchanged.
  - With total=90, code 3 → reject, total stays 90.
  - With total=90, code 2 → accept, total=95.
- Clear collision: total=35, `i_clear` and a coin (code 0) in the same cycle → total=0 and reject pulse.
- Disable hold:
  - Total=20, drop `i_enable` mid-settle → state DISABLED, `o_busy`=0, total holds 20.
  - A coin strobe while disabled → reject.
- Reset mid-operation: assert `i_rst` asynchronously with total=50 during settle → all outputs 0 before the next edge, FSM in DISABLED.
